uart_rx_engine: RTL and testbench

//  Parametrised UART receive engine: oversampled start detection, mid-bit sampling,
//  LSB-first deserialisation, optional parity, 1/2 stop bits, valid/rdy output handshake.

---
 rtl/uart_rx_engine_if.sv | 22 ++
 rtl/uart_rx_engine.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_engine_if.sv
// Receive-side handshake between uart_rx_engine (master) and its consumer (slave):
// held frame, its error flags, the sticky overrun flag and the consumer's ready.
interface uart_rx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dat_o;
    logic                 valid;
    logic                 rdy;
    logic                 parErr;
    logic                 frmErr;
    logic                 ovrErr;

    modport master (
        output dat_o, valid, parErr, frmErr, ovrErr,
        input  rdy
    );

    modport slave (
        input  dat_o, valid, parErr, frmErr, ovrErr,
        output rdy
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start detection, mid-bit sampling, LSB-first payload,
// optional parity, 1/2 stop bits. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx_engine #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             brTick,
    input  logic             rx,
    output logic             busy,
    uart_rx_engine_if.master bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        sIdle,
        sStart,
        sData,
        sParity,
        sStop,
        sWaitHi
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic                 rxMeta;
    logic                 rxS;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bitCnt;
    logic                 stopCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parErrAcc;
    logic                 frmErrAcc;
    logic                 bitVal;
    logic                 spNow;
    logic                 wrap;
    logic                 lastStop;
    logic                 parExp;
    logic                 startFrame;
    logic                 frameDone;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_SP  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(OVERSAMPLE / 2 - 1);

    logic voteA;
    logic voteB;

    // The two early votes are captured here; the third is rxS at the decision tick itself.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            voteA <= 1'b1;
            voteB <= 1'b1;
        end else if (brTick) begin
            if (cnt == CNT_PRE) voteA <= rxS;
            if (cnt == CNT_MID) voteB <= rxS;
        end
    end

    assign bitVal = (voteA & voteB) | (voteA & rxS) | (voteB & rxS);
`else
    localparam logic [CNT_W-1:0] CNT_SP = CNT_MID;

    assign bitVal = rxS;
`endif

    assign spNow    = brTick && (cnt == CNT_SP);
    assign wrap     = brTick && (cnt == CNT_LAST);
    assign lastStop = (STOP_BITS == 1) || stopCnt;
    assign parExp   = (PARITY == 2) ? ^shiftReg : ~^shiftReg;
    assign busy     = (state != sIdle);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= sIdle;
        else       state <= stateNext;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        frameDone  = 1'b0;
        if (brTick) begin
            unique case (state)
                sIdle: begin
                    if (!rxS) begin
                        stateNext  = sStart;
                        startFrame = 1'b1;
                    end
                end
                sStart: begin
                    if (spNow && bitVal) stateNext = sIdle;
                    else if (wrap)       stateNext = sData;
                end
                sData: begin
                    if (wrap && (bitCnt == BIT_LAST))
                        stateNext = (PARITY != 0) ? sParity : sStop;
                end
                sParity: begin
                    if (wrap) stateNext = sStop;
                end
                sStop: begin
                    // Last stop bit is resolved at its sample point so a following start edge is caught.
                    if (spNow && lastStop) begin
                        frameDone = 1'b1;
                        stateNext = bitVal ? sIdle : sWaitHi;
                    end else if (wrap) begin
                        stateNext = sStop;
                    end
                end
                sWaitHi: begin
                    if (rxS) stateNext = sIdle;
                end
                default: stateNext = sIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt       <= '0;
            bitCnt    <= '0;
            stopCnt   <= 1'b0;
            shiftReg  <= '0;
            parErrAcc <= 1'b0;
            frmErrAcc <= 1'b0;
        end else if (brTick) begin
            if (startFrame) begin
                cnt       <= '0;
                bitCnt    <= '0;
                stopCnt   <= 1'b0;
                parErrAcc <= 1'b0;
                frmErrAcc <= 1'b0;
            end else begin
                if (stateNext == sIdle) cnt <= '0;
                else                    cnt <= wrap ? '0 : cnt + 1'b1;
                if (state == sData && spNow)            shiftReg  <= {bitVal, shiftReg[DATA_BITS-1:1]};
                if (state == sData && wrap)             bitCnt    <= bitCnt + 1'b1;
                if (state == sParity && spNow)          parErrAcc <= bitVal ^ parExp;
                if (state == sStop && spNow && !bitVal) frmErrAcc <= 1'b1;
                if (state == sStop && wrap)             stopCnt   <= ~stopCnt;
            end
        end
    end

    // Output holding register: a completing frame wins over acceptance, an unaccepted one flags overrun.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            bus.dat_o  <= '0;
            bus.valid  <= 1'b0;
            bus.parErr <= 1'b0;
            bus.frmErr <= 1'b0;
            bus.ovrErr <= 1'b0;
        end else if (frameDone) begin
            bus.dat_o  <= shiftReg;
            bus.valid  <= 1'b1;
            bus.parErr <= (PARITY != 0) && parErrAcc;
            bus.frmErr <= frmErrAcc | ~bitVal;
            if (bus.valid && !bus.rdy)     bus.ovrErr <= 1'b1;
            else if (bus.valid && bus.rdy) bus.ovrErr <= 1'b0;
        end else if (bus.valid && bus.rdy) begin
            bus.valid  <= 1'b0;
            bus.ovrErr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine (OVERSAMPLE=8, DATA_BITS=8, even parity, 1 stop bit).
// Expected frames are queued as they are sent and compared when the consumer accepts them.
module tb_uart_rx_engine;
    localparam int OS      = 8;
    localparam int DIV     = 4;
    localparam int BIT_CLK = OS * DIV;

    typedef struct {
        logic [7:0] dat;
        logic       par;
        logic       frm;
    } frameT;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       rx = 1'b1;
    logic       busy;
    logic [1:0] tickDiv = '0;
    logic       brTick;

    frameT sb[$];
    frameT exp;
    int    errors = 0;
    int    checks = 0;
    int    validCycles = 0;
    int    busyCycles = 0;

    uart_rx_engine_if #(.DATA_BITS(8)) ifc ();

    uart_rx_engine #(
        .OVERSAMPLE(OS),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (1)
    ) dut (
        .clk   (clk),
        .arst  (arst),
        .brTick(brTick),
        .rx    (rx),
        .busy  (busy),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tickDiv <= tickDiv + 2'd1;
    assign brTick = (tickDiv == 2'(DIV - 1));

    // Consumer side: every accepted frame is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (arst && ifc.valid) validCycles++;
        if (arst && busy) busyCycles++;
        if (arst && ifc.valid && ifc.rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected dat_o=%h parErr=%b frmErr=%b", ifc.dat_o, ifc.parErr, ifc.frmErr);
            end else begin
                exp = sb.pop_front();
                checks += 3;
                if (ifc.dat_o !== exp.dat) begin
                    errors++;
                    $display("FAIL frame_dat got=%h want=%h", ifc.dat_o, exp.dat);
                end
                if (ifc.parErr !== exp.par) begin
                    errors++;
                    $display("FAIL frame_parErr got=%b want=%b (dat %h)", ifc.parErr, exp.par, exp.dat);
                end
                if (ifc.frmErr !== exp.frm) begin
                    errors++;
                    $display("FAIL frame_frmErr got=%b want=%b (dat %h)", ifc.frmErr, exp.frm, exp.dat);
                end
            end
        end
    end

    // Called in the phase just after a posedge; waits until that edge carried a brTick.
    task automatic alignTick();
        while (tickDiv != 2'd0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveBit(input logic b, input int clocks);
        rx = b;
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic parBit, input logic stopBit);
        alignTick();
        driveBit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) driveBit(d[i], BIT_CLK);
        driveBit(parBit, BIT_CLK);
        driveBit(stopBit, BIT_CLK);
    endtask

    task automatic sendGood(input logic [7:0] d);
        sb.push_back('{d, 1'b0, 1'b0});
        sendFrame(d, ^d, 1'b1);
    endtask

    task automatic checkDrained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained pending=%0d want=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        ifc.rdy = 1'b1;
        arst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks += 6;
        if (ifc.valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b want=0", ifc.valid); end
        if (ifc.dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat got=%h want=00", ifc.dat_o); end
        if (ifc.parErr !== 1'b0) begin errors++; $display("FAIL reset_parErr got=%b want=0", ifc.parErr); end
        if (ifc.frmErr !== 1'b0) begin errors++; $display("FAIL reset_frmErr got=%b want=0", ifc.frmErr); end
        if (ifc.ovrErr !== 1'b0) begin errors++; $display("FAIL reset_ovrErr got=%b want=0", ifc.ovrErr); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        arst = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        int v0 = validCycles;
        sendGood(8'hA5);
        repeat (4) @(posedge clk);
        #1;
        checkDrained("frame");
        checks += 3;
        if (validCycles - v0 != 1) begin errors++; $display("FAIL frame_valid_width got=%0d want=1", validCycles - v0); end
        if (ifc.dat_o !== 8'hA5)   begin errors++; $display("FAIL frame_hold got=%h want=a5", ifc.dat_o); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL frame_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_false_start();
        int v0 = validCycles;
        int b0 = busyCycles;
        alignTick();
        driveBit(1'b0, 2 * DIV);
        driveBit(1'b1, 2 * BIT_CLK);
        checks += 3;
        if (busyCycles - b0 < 18 || busyCycles - b0 > 22) begin
            errors++;
            $display("FAIL false_start_busy_cycles got=%0d want=18..22", busyCycles - b0);
        end
        if (busy !== 1'b0)    begin errors++; $display("FAIL false_start_idle got=%b want=0", busy); end
        if (validCycles != v0) begin errors++; $display("FAIL false_start_valid got=%0d want=0", validCycles - v0); end
    endtask

    task automatic test_errors();
        sb.push_back('{8'h3C, 1'b1, 1'b0});
        sendFrame(8'h3C, 1'b1, 1'b1);
        sb.push_back('{8'h00, 1'b0, 1'b1});
        sendFrame(8'h00, 1'b0, 1'b0);
        driveBit(1'b0, 2 * BIT_CLK);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held got=%b want=1", busy); end
        driveBit(1'b1, 2 * BIT_CLK);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_release got=%b want=0", busy); end
        checkDrained("errors");
    endtask

    task automatic test_overrun();
        ifc.rdy = 1'b0;
        sendFrame(8'h11, 1'b0, 1'b1);
        checks += 2;
        if (ifc.valid !== 1'b1)  begin errors++; $display("FAIL ovr_first_valid got=%b want=1", ifc.valid); end
        if (ifc.ovrErr !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got=%b want=0", ifc.ovrErr); end
        sb.push_back('{8'h22, 1'b0, 1'b0});
        sendFrame(8'h22, 1'b0, 1'b1);
        checks += 3;
        if (ifc.valid !== 1'b1)  begin errors++; $display("FAIL ovr_valid got=%b want=1", ifc.valid); end
        if (ifc.dat_o !== 8'h22) begin errors++; $display("FAIL ovr_dat got=%h want=22", ifc.dat_o); end
        if (ifc.ovrErr !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b want=1", ifc.ovrErr); end
        ifc.rdy = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (ifc.valid !== 1'b0)  begin errors++; $display("FAIL ovr_accept_valid got=%b want=0", ifc.valid); end
        if (ifc.ovrErr !== 1'b0) begin errors++; $display("FAIL ovr_accept_flag got=%b want=0", ifc.ovrErr); end
        checkDrained("overrun");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'h5A;
        int v0;
        alignTick();
        driveBit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) driveBit(d[i], BIT_CLK);
        driveBit(d[4], BIT_CLK / 2);
        arst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (ifc.valid !== 1'b0)  begin errors++; $display("FAIL arst_valid got=%b want=0", ifc.valid); end
        if (ifc.dat_o !== 8'h00) begin errors++; $display("FAIL arst_dat got=%h want=00", ifc.dat_o); end
        if (ifc.frmErr !== 1'b0) begin errors++; $display("FAIL arst_frmErr got=%b want=0", ifc.frmErr); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL arst_busy got=%b want=0", busy); end
        rx = 1'b1;
        arst = 1'b1;
        v0 = validCycles;
        driveBit(1'b1, 2 * BIT_CLK);
        sendGood(8'hC3);
        repeat (4) @(posedge clk);
        #1;
        checks += 2;
        if (validCycles - v0 != 1) begin errors++; $display("FAIL arst_frames got=%0d want=1", validCycles - v0); end
        if (ifc.dat_o !== 8'hC3)   begin errors++; $display("FAIL arst_resume_dat got=%h want=c3", ifc.dat_o); end
        checkDrained("reset_mid_frame");
    endtask

    task automatic test_back_to_back();
        int v0 = validCycles;
        sendGood(8'hFF);
        sendGood(8'h80);
        sendGood(8'h5B);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (validCycles - v0 != 3) begin errors++; $display("FAIL b2b_frames got=%0d want=3", validCycles - v0); end
        checkDrained("back_to_back");
    endtask

    // One-tick high pulse centred on the single-sample point of data bit 0 of 0x00.
    task automatic test_glitch();
`ifdef UART_RX_MAJORITY_EN
        sb.push_back('{8'h00, 1'b0, 1'b0});
`else
        sb.push_back('{8'h01, 1'b1, 1'b0});
`endif
        alignTick();
        driveBit(1'b0, BIT_CLK);
        driveBit(1'b0, 20);
        driveBit(1'b1, DIV);
        driveBit(1'b0, BIT_CLK - 20 - DIV);
        for (int i = 1; i < 8; i++) driveBit(1'b0, BIT_CLK);
        driveBit(1'b0, BIT_CLK);
        driveBit(1'b1, BIT_CLK);
        repeat (4) @(posedge clk);
        #1;
        checkDrained("glitch");
    endtask

    initial begin
        ifc.rdy = 1'b1;
        #1;
        test_reset();
        test_frame();
        test_false_start();
        test_errors();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
